// File: rtl/mapper_power_ctrl.sv
// mapper_power_ctrl
//   Sequencer for the mapper power / reference-level estimator. Paces the
//   estimator symbol strobe (clk_en) from the sample clock, counts an
//   averaging window of 2^LOG2_N symbols, and closes each window with a
//   one-cycle clear_accum pulse. SETTLE cycles after every clear_accum, the
//   estimator results are captured into held output registers. The first
//   DISCARD captures after each start from IDLE are dropped.
//
// Handshake (valid/ack):
//   valid is a held level. ack is only meaningful while valid=1: ack=1 with
//   valid=1 clears valid and overrun on the next edge. ack with valid=0 is
//   ignored. A capture while valid=1 and ack=0 overwrites the data and sets
//   the sticky overrun flag. A capture coinciding with ack loads the new data,
//   keeps valid=1 and does not set overrun.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   enable              1 = run windows continuously, 0 = stop at next boundary
//   ack                 downstream accepts the held result
//   mapper_power_in     estimator mapper_power (18-bit signed)
//   ref_level_in        estimator ref_level (18-bit signed)
//   clk_en              symbol strobe to the estimator
//   clear_accum         window-boundary pulse to the estimator
//   mapper_power_out    captured mapper power
//   ref_level_out       captured reference level
//   valid, overrun      handshake status (see above)
//   busy                FSM is not in IDLE
//   window_count        completed windows, wraps 0xFFFF -> 0
//   state_dbg           current FSM state encoding (debug only)
module mapper_power_ctrl #(
  parameter int SPS     = 4,
  parameter int LOG2_N  = 20,
  parameter int SETTLE  = 2,
  parameter int DISCARD = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               ack,
  input  logic signed [17:0] mapper_power_in,
  input  logic signed [17:0] ref_level_in,
  output logic               clk_en,
  output logic               clear_accum,
  output logic signed [17:0] mapper_power_out,
  output logic signed [17:0] ref_level_out,
  output logic               valid,
  output logic               overrun,
  output logic               busy,
  output logic [15:0]        window_count,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic [7:0] SPS_M1    = 8'(SPS - 1);
  localparam logic [3:0] SETTLE_L  = 4'(SETTLE);
  localparam logic [1:0] DISCARD_L = 2'(DISCARD);

  state_t              state_q, state_d;
  logic                start_q, start_d;
  logic [7:0]          samp_q, samp_d;
  logic [LOG2_N-1:0]   sym_q, sym_d;
  logic [3:0]          settle_q, settle_d;
  logic [1:0]          disc_q, disc_d;
  logic signed [17:0]  mp_q, mp_d;
  logic signed [17:0]  ref_q, ref_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         window_count_q, window_count_d;
  logic                clk_en_q, clk_en_d;
  logic                clear_q, clear_d;
  logic                capture;

  // Capture fires on the last cycle of the settle countdown.
  assign capture = (settle_q == 4'd1);

  always_comb begin
    state_d        = state_q;
    start_d        = start_q;
    samp_d         = samp_q;
    sym_d          = sym_q;
    settle_d       = settle_q;
    disc_d         = disc_q;
    mp_d           = mp_q;
    ref_d          = ref_q;
    valid_d        = valid_q;
    overrun_d      = overrun_q;
    window_count_d = window_count_q;

    // Settle timer runs independently of the FSM so the capture after a
    // terminal CLEAR still happens once the FSM is back in IDLE.
    if (state_q == S_CLEAR) begin
      settle_d = SETTLE_L;
    end else if (settle_q != 4'd0) begin
      settle_d = settle_q - 4'd1;
    end

    if (ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    if (capture) begin
      if (disc_q != 2'd0) begin
        disc_d = disc_q - 2'd1;
      end else begin
        mp_d    = mapper_power_in;
        ref_d   = ref_level_in;
        valid_d = 1'b1;
        if (valid_q && !ack) begin
          overrun_d = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_CLEAR;
          start_d = 1'b1;
          // A fresh start re-primes the estimator pipeline; takes priority
          // over a pending capture decrement.
          disc_d  = DISCARD_L;
        end
      end
      S_CLEAR: begin
        samp_d  = 8'd0;
        sym_d   = '0;
        start_d = 1'b0;
        if (!start_q) begin
          window_count_d = window_count_q + 16'd1;
        end
        state_d = (enable || start_q) ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (samp_q == SPS_M1) begin
          samp_d = 8'd0;
          sym_d  = sym_q + 1'b1;
          if (sym_q == '1) begin
            state_d = S_CLEAR;
          end
        end else begin
          samp_d = samp_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered from next-state so they line up with the
    // cycle in which the FSM/counter actually holds that value.
    clk_en_d = (state_d == S_RUN) && (samp_d == SPS_M1);
    clear_d  = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      start_q        <= 1'b0;
      samp_q         <= 8'd0;
      sym_q          <= '0;
      settle_q       <= 4'd0;
      disc_q         <= 2'd0;
      mp_q           <= '0;
      ref_q          <= '0;
      valid_q        <= 1'b0;
      overrun_q      <= 1'b0;
      window_count_q <= 16'd0;
      clk_en_q       <= 1'b0;
      clear_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_d;
      samp_q         <= samp_d;
      sym_q          <= sym_d;
      settle_q       <= settle_d;
      disc_q         <= disc_d;
      mp_q           <= mp_d;
      ref_q          <= ref_d;
      valid_q        <= valid_d;
      overrun_q      <= overrun_d;
      window_count_q <= window_count_d;
      clk_en_q       <= clk_en_d;
      clear_q        <= clear_d;
    end
  end

  assign clk_en           = clk_en_q;
  assign clear_accum      = clear_q;
  assign mapper_power_out = mp_q;
  assign ref_level_out    = ref_q;
  assign valid            = valid_q;
  assign overrun          = overrun_q;
  assign busy             = (state_q != S_IDLE);
  assign window_count     = window_count_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_mapper_power_ctrl.sv
// Directed bench for mapper_power_ctrl with SPS=4, LOG2_N=3, SETTLE=2,
// DISCARD=2 (window period 33 cycles). Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_mapper_power_ctrl;

  localparam int SPS     = 4;
  localparam int LOG2_N  = 3;
  localparam int SETTLE  = 2;
  localparam int DISCARD = 2;
  localparam int PERIOD  = SPS * (1 << LOG2_N) + 1;

  logic               clk;
  logic               reset;
  logic               enable;
  logic               ack;
  logic signed [17:0] mp_in;
  logic signed [17:0] ref_in;
  logic               clk_en;
  logic               clear_accum;
  logic signed [17:0] mp_out;
  logic signed [17:0] ref_out;
  logic               valid;
  logic               overrun;
  logic               busy;
  logic [15:0]        window_count;
  logic [1:0]         state_dbg;
  logic [56:0]        all_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [35:0] exp_q[$];

  mapper_power_ctrl #(
    .SPS(SPS), .LOG2_N(LOG2_N), .SETTLE(SETTLE), .DISCARD(DISCARD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ack(ack),
    .mapper_power_in(mp_in),
    .ref_level_in(ref_in),
    .clk_en(clk_en),
    .clear_accum(clear_accum),
    .mapper_power_out(mp_out),
    .ref_level_out(ref_out),
    .valid(valid),
    .overrun(overrun),
    .busy(busy),
    .window_count(window_count),
    .state_dbg(state_dbg)
  );

  assign all_out = {clk_en, clear_accum, mp_out, ref_out, valid, overrun, busy, window_count};

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_data(input string tag);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {28'd0, mp_out, ref_out}, {28'd0, e});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_clear(output int c);
    int k;
    for (k = 0; k < 3 * PERIOD; k++) begin
      @(negedge clk);
      if (clear_accum) break;
    end
    if (k == 3 * PERIOD) chk("clear_timeout", 64'(clear_accum), 64'd1);
    c = int'($time / 10);
  endtask

  task automatic new_data();
    mp_in  = 18'($urandom_range(0, 262143));
    ref_in = 18'($urandom_range(0, 262143));
    exp_q.push_back({mp_in, ref_in});
  endtask

  // ---------------- strobe / pulse monitor ----------------
  int   last_evt = -1;
  int   strobes = 0;
  int   last_win_strobes = 0;
  int   n_clears = 0;
  logic prev_clear = 1'b0;

  always @(negedge clk) begin
    int cyc;
    cyc = int'($time / 10);
    if (reset) begin
      strobes    = 0;
      last_evt   = -1;
      prev_clear = 1'b0;
    end else begin
      if (clk_en || clear_accum) chk("exclusive", 64'(clk_en & clear_accum), 64'd0);
      if (clk_en) begin
        if (last_evt >= 0) chk("strobe_spacing", 64'(cyc - last_evt), 64'(SPS));
        strobes++;
        last_evt = cyc;
      end
      if (clear_accum) begin
        chk("clear_back_to_back", 64'(prev_clear), 64'd0);
        last_win_strobes = strobes;
        strobes  = 0;
        last_evt = cyc;
        n_clears++;
      end
      prev_clear = clear_accum;
    end
  end

  // Start from IDLE, confirm the two discarded captures, then the first
  // real capture after the second terminal CLEAR.
  task automatic run_discard();
    int c0, c1, c2;
    mp_in  = 18'h00500;
    ref_in = 18'h00400;
    reset  = 1'b0;
    enable = 1'b1;
    tick(1);
    chk("start_clear", 64'(clear_accum), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    c0 = int'($time / 10);
    tick(3);
    chk("discard_start_valid", 64'(valid), 64'd0);
    wait_clear(c1);
    chk("period_1", 64'(c1 - c0), 64'(PERIOD));
    tick(1);
    chk("strobes_1", 64'(last_win_strobes), 64'(1 << LOG2_N));
    chk("wcount_1", 64'(window_count), 64'd1);
    tick(2);
    chk("discard_term1_valid", 64'(valid), 64'd0);
    wait_clear(c2);
    chk("period_2", 64'(c2 - c1), 64'(PERIOD));
    exp_q.push_back({18'h00500, 18'h00400});
    tick(2);
    chk("capture_latency", 64'(valid), 64'd0);
    tick(1);
    chk("first_valid", 64'(valid), 64'd1);
    chk_data("first_data");
    chk("wcount_2", 64'(window_count), 64'd2);
    chk("first_overrun", 64'(overrun), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c3, c4, c5, c6, c7, c8;
    int clears_before;
    reset  = 1'b1;
    enable = 1'b0;
    ack    = 1'b0;
    mp_in  = '0;
    ref_in = '0;

    // Reset state, then a start interrupted mid-window by reset.
    tick(3);
    chk("reset_outputs", 64'(all_out), 64'd0);
    reset = 1'b0;
    tick(1);
    chk("idle_busy", 64'(busy), 64'd0);
    enable = 1'b1;
    tick(1);
    chk("start_latency", 64'(clear_accum), 64'd1);
    tick(10);
    reset = 1'b1;
    #1;
    chk("reset_async", 64'(all_out), 64'd0);
    tick(2);
    chk("reset_held", 64'(all_out), 64'd0);

    // Capture and discard.
    run_discard();

    // Handshake and overrun.
    new_data();
    wait_clear(c3);
    tick(3);
    chk("ovr_valid", 64'(valid), 64'd1);
    chk("ovr_flag", 64'(overrun), 64'd1);
    chk_data("ovr_data");
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("ack_valid", 64'(valid), 64'd0);
    chk("ack_overrun", 64'(overrun), 64'd0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("ack_idle_valid", 64'(valid), 64'd0);
    new_data();
    wait_clear(c4);
    tick(3);
    chk("cap4_valid", 64'(valid), 64'd1);
    chk("cap4_overrun", 64'(overrun), 64'd0);
    chk_data("cap4_data");
    new_data();
    wait_clear(c5);
    tick(2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("ackcap_valid", 64'(valid), 64'd1);
    chk("ackcap_overrun", 64'(overrun), 64'd0);
    chk_data("ackcap_data");
    chk("wcount_5", 64'(window_count), 64'd5);
    new_data();

    // Graceful stop: drop enable on strobe 3 of the window after c6.
    wait_clear(c6);
    tick(3);
    chk_data("cap6_data");
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    new_data();
    tick(8);
    chk("strobe3", 64'(clk_en), 64'd1);
    enable = 1'b0;
    wait_clear(c7);
    chk("stop_period", 64'(c7 - c6), 64'(PERIOD));
    tick(1);
    chk("stop_strobes", 64'(last_win_strobes), 64'(1 << LOG2_N));
    chk("stop_busy", 64'(busy), 64'd0);
    tick(1);
    chk("stop_pre_capture", 64'(valid), 64'd0);
    tick(1);
    chk("stop_capture_valid", 64'(valid), 64'd1);
    chk_data("stop_capture_data");
    chk("wcount_7", 64'(window_count), 64'd7);
    clears_before = n_clears;
    tick(40);
    chk("stop_no_clear", 64'(n_clears - clears_before), 64'd0);
    chk("stop_idle_busy", 64'(busy), 64'd0);

    // Reset inside the settle window while valid=1, then restart.
    enable = 1'b1;
    tick(1);
    chk("restart_clear", 64'(clear_accum), 64'd1);
    c8 = int'($time / 10);
    tick(1);
    reset = 1'b1;
    #1;
    chk("midrst_async", 64'(all_out), 64'd0);
    tick(1);
    chk("midrst_held", 64'(all_out), 64'd0);
    run_discard();

    // Wrap of the window counter.
    force dut.window_count_q = 16'hFFFF;
    tick(1);
    release dut.window_count_q;
    wait_clear(c3);
    tick(1);
    chk("wcount_wrap", 64'(window_count), 64'd0);

    enable = 1'b0;
    tick(2 * PERIOD);
    chk("final_busy", 64'(busy), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
